// File: rtl/instr_types_pkg.sv
// instr_types_pkg: shared rename types; physical register tags and free-list sizing.
package instr_types_pkg;
    localparam int NUM_ARCH_REGS = 32;
    localparam int NUM_PHYS_REGS = 64;
    localparam int FREE_LIST_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    typedef logic [$clog2(NUM_PHYS_REGS)-1:0] phys_reg_tag_t;
    typedef logic [$clog2(FREE_LIST_DEPTH)-1:0] free_list_ptr_t;
    typedef logic [$clog2(FREE_LIST_DEPTH+1)-1:0] free_count_t;
endpackage

// File: rtl/phys_reg_free_list_if.sv
// phys_reg_free_list_if: rename dequeue handshake plus commit/kill tag return ports.
interface phys_reg_free_list_if;
    import instr_types_pkg::*;
    logic          dequeue_req;
    logic          dequeue_ready;
    phys_reg_tag_t dequeue_phys_reg_tag;
    logic          commit_free_valid;
    phys_reg_tag_t commit_free_phys_reg_tag;
    logic          kill_free_valid;
    phys_reg_tag_t kill_free_phys_reg_tag;
    free_count_t   free_count;
    logic          overflow_error;
    modport master (
        output dequeue_req, commit_free_valid, commit_free_phys_reg_tag,
               kill_free_valid, kill_free_phys_reg_tag,
        input  dequeue_ready, dequeue_phys_reg_tag, free_count, overflow_error
    );
    modport slave (
        input  dequeue_req, commit_free_valid, commit_free_phys_reg_tag,
               kill_free_valid, kill_free_phys_reg_tag,
        output dequeue_ready, dequeue_phys_reg_tag, free_count, overflow_error
    );
endinterface

// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list: circular FIFO of free physical register tags feeding rename.
// Define PHYS_REG_FREE_LIST_BYPASS_EN to let an empty list hand a same-cycle commit tag straight to rename.
module phys_reg_free_list #(
    parameter int NUM_ARCH_REGS   = instr_types_pkg::NUM_ARCH_REGS,
    parameter int NUM_PHYS_REGS   = instr_types_pkg::NUM_PHYS_REGS,
    parameter int FREE_LIST_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS
) (
    input logic CLK,
    input logic nRST,
    phys_reg_free_list_if.slave fl
);
    import instr_types_pkg::*;
    localparam int PW = (FREE_LIST_DEPTH > 1) ? $clog2(FREE_LIST_DEPTH) : 1;
    localparam int CW = $clog2(FREE_LIST_DEPTH + 1);
    localparam int TW = $bits(phys_reg_tag_t);

    logic [FREE_LIST_DEPTH-1:0][TW-1:0] entries;
    logic [PW-1:0] head_ptr, tail_ptr, kill_ptr;
    logic [CW-1:0] count, next_count;
    logic [CW:0]   base;
    logic          overflow_error;
    logic          bypass, fire, pop, commit_req, commit_en, kill_en, drop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FREE_LIST_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
`ifdef PHYS_REG_FREE_LIST_BYPASS_EN
        bypass = (count == '0) && fl.commit_free_valid;
`else
        bypass = 1'b0;
`endif
        fl.dequeue_ready        = (count != '0) || bypass;
        fl.dequeue_phys_reg_tag = bypass ? fl.commit_free_phys_reg_tag : phys_reg_tag_t'(entries[head_ptr]);
        fire       = fl.dequeue_req && fl.dequeue_ready;
        pop        = fire && !bypass;
        // A bypassed commit tag is consumed directly and never occupies an entry.
        commit_req = fl.commit_free_valid && !(bypass && fire);
        base       = {1'b0, count} - (CW+1)'(pop);
        // Overflow drops the kill write before the commit write.
        commit_en  = commit_req && (int'(base) + 1 <= FREE_LIST_DEPTH);
        kill_en    = fl.kill_free_valid && (int'(base) + int'(commit_req) + 1 <= FREE_LIST_DEPTH);
        drop       = (commit_req && !commit_en) || (fl.kill_free_valid && !kill_en);
        kill_ptr   = commit_en ? ptr_inc(tail_ptr) : tail_ptr;
        next_count = CW'(int'(base) + int'(commit_en) + int'(kill_en));
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < FREE_LIST_DEPTH; i++)
                entries[i] <= TW'(NUM_ARCH_REGS + i);
            head_ptr       <= '0;
            tail_ptr       <= '0;
            count          <= CW'(FREE_LIST_DEPTH);
            overflow_error <= 1'b0;
        end else begin
            if (commit_en) entries[tail_ptr] <= fl.commit_free_phys_reg_tag;
            if (kill_en) entries[kill_ptr] <= fl.kill_free_phys_reg_tag;
            head_ptr <= pop ? ptr_inc(head_ptr) : head_ptr;
            tail_ptr <= kill_en ? ptr_inc(kill_ptr) : (commit_en ? ptr_inc(tail_ptr) : tail_ptr);
            count    <= next_count;
            if (drop) overflow_error <= 1'b1;
        end
    end

    assign fl.free_count     = free_count_t'(count);
    assign fl.overflow_error = overflow_error;
endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb_phys_reg_free_list: directed self-checking bench for phys_reg_free_list.
module tb_phys_reg_free_list;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int checks = 0;
    int failures = 0;

    phys_reg_free_list_if fl();
    phys_reg_free_list dut (.CLK(CLK), .nRST(nRST), .fl(fl));

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        fl.dequeue_req = 0;
        fl.commit_free_valid = 0;
        fl.commit_free_phys_reg_tag = '0;
        fl.kill_free_valid = 0;
        fl.kill_free_phys_reg_tag = '0;
    endtask

    task automatic do_reset();
        idle();
        nRST = 0;
        tick();
        nRST = 1;
        tick();
    endtask

    task automatic drain_all();
        fl.dequeue_req = 1;
        for (int i = 0; i < 32; i++) begin
            check("drain_tag", 32'(fl.dequeue_phys_reg_tag), 32'(32 + i));
            tick();
        end
        fl.dequeue_req = 0;
    endtask

    initial begin
        idle();
        do_reset();
        check("rst_ready", 32'(fl.dequeue_ready), 1);
        check("rst_tag", 32'(fl.dequeue_phys_reg_tag), 32);
        check("rst_count", 32'(fl.free_count), 32);
        check("rst_ovf", 32'(fl.overflow_error), 0);

        drain_all();
        check("empty_ready", 32'(fl.dequeue_ready), 0);
        check("empty_count", 32'(fl.free_count), 0);

        // commit 5, then kill 9, then two dequeues
        fl.commit_free_valid = 1; fl.commit_free_phys_reg_tag = 5;
        tick();
        idle();
        check("seq_count1", 32'(fl.free_count), 1);
        fl.kill_free_valid = 1; fl.kill_free_phys_reg_tag = 9;
        tick();
        idle();
        check("seq_count2", 32'(fl.free_count), 2);
        fl.dequeue_req = 1;
        check("seq_tag5", 32'(fl.dequeue_phys_reg_tag), 5);
        tick();
        check("seq_count3", 32'(fl.free_count), 1);
        check("seq_tag9", 32'(fl.dequeue_phys_reg_tag), 9);
        tick();
        idle();
        check("seq_count4", 32'(fl.free_count), 0);

        // commit 7 and kill 12 in the same cycle
        fl.commit_free_valid = 1; fl.commit_free_phys_reg_tag = 7;
        fl.kill_free_valid = 1; fl.kill_free_phys_reg_tag = 12;
        tick();
        idle();
        check("dual_count", 32'(fl.free_count), 2);
        fl.dequeue_req = 1;
        check("dual_tag7", 32'(fl.dequeue_phys_reg_tag), 7);
        tick();
        check("dual_tag12", 32'(fl.dequeue_phys_reg_tag), 12);
        tick();
        idle();
        check("dual_empty", 32'(fl.free_count), 0);

        // full list: dequeue + commit 3 together
        do_reset();
        fl.dequeue_req = 1;
        fl.commit_free_valid = 1; fl.commit_free_phys_reg_tag = 3;
        check("full_deq_tag", 32'(fl.dequeue_phys_reg_tag), 32);
        tick();
        fl.commit_free_valid = 0;
        check("full_deq_count", 32'(fl.free_count), 32);
        check("full_deq_ovf", 32'(fl.overflow_error), 0);
        for (int i = 1; i < 32; i++) begin
            check("full_deq_walk", 32'(fl.dequeue_phys_reg_tag), 32'(32 + i));
            tick();
        end
        check("full_deq_tag3", 32'(fl.dequeue_phys_reg_tag), 3);
        tick();
        idle();
        check("full_deq_empty", 32'(fl.free_count), 0);

        // full list: commit with no dequeue is dropped
        do_reset();
        fl.commit_free_valid = 1; fl.commit_free_phys_reg_tag = 3;
        tick();
        idle();
        check("ovf_set", 32'(fl.overflow_error), 1);
        check("ovf_count", 32'(fl.free_count), 32);
        check("ovf_head", 32'(fl.dequeue_phys_reg_tag), 32);
        tick();
        check("ovf_sticky", 32'(fl.overflow_error), 1);
        fl.dequeue_req = 1;
        tick();
        idle();
        check("pre_rst_count", 32'(fl.free_count), 31);
        check("pre_rst_tag", 32'(fl.dequeue_phys_reg_tag), 33);
        #2 nRST = 0;
        #1;
        check("async_rst_count", 32'(fl.free_count), 32);
        check("async_rst_tag", 32'(fl.dequeue_phys_reg_tag), 32);
        check("async_rst_ovf", 32'(fl.overflow_error), 0);
        tick();
        nRST = 1;
        tick();

        // empty list with commit 20 and dequeue_req in the same cycle
        drain_all();
        fl.dequeue_req = 1;
        fl.commit_free_valid = 1; fl.commit_free_phys_reg_tag = 20;
        #1;
`ifdef PHYS_REG_FREE_LIST_BYPASS_EN
        check("byp_ready", 32'(fl.dequeue_ready), 1);
        check("byp_tag", 32'(fl.dequeue_phys_reg_tag), 20);
        tick();
        idle();
        check("byp_count", 32'(fl.free_count), 0);
        check("byp_ready_after", 32'(fl.dequeue_ready), 0);
`else
        check("nobyp_ready", 32'(fl.dequeue_ready), 0);
        tick();
        idle();
        check("nobyp_count", 32'(fl.free_count), 1);
        check("nobyp_tag", 32'(fl.dequeue_phys_reg_tag), 20);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/phys_reg_free_list.md
# phys_reg_free_list

Circular FIFO of unallocated physical register tags feeding rename. Each renamed instruction with a destination dequeues one tag, which rename writes into the phys reg map table as the new mapping. Tags return on two ports:
- commit, which frees the old mapping's tag;
- kill/restore walk, which frees the killed instruction's new tag.

Sits beside the map table in the core, between decode/rename and ROB.

## Interface
Parameters:
- NUM_ARCH_REGS, default 32, architectural register count; also the first tag held at reset.
- NUM_PHYS_REGS, default 64, physical register count.
- FREE_LIST_DEPTH, default NUM_PHYS_REGS - NUM_ARCH_REGS, entry count.

Ports (`phys_reg_tag_t` is from the shared package):
- CLK  in  1  clock; all state on posedge.
- nRST  in  1  asynchronous active-low reset.
- dequeue_req  in  1  rename wants a tag this cycle.
- dequeue_ready  out  1  a tag is available; dequeue fires iff dequeue_req && dequeue_ready.
- dequeue_phys_reg_tag  out  phys_reg_tag_t  tag at head; combinational.
- commit_free_valid  in  1  commit returns a tag.
- commit_free_phys_reg_tag  in  phys_reg_tag_t  freed old tag.
- kill_free_valid  in  1  kill walk returns a tag.
- kill_free_phys_reg_tag  in  phys_reg_tag_t  freed new tag.
- free_count  out  $clog2(FREE_LIST_DEPTH+1)  current occupancy.
- overflow_error  out  1  sticky; set on any dropped enqueue.

## Operation
State:
- entry array[FREE_LIST_DEPTH];
- head_ptr and tail_ptr, each $clog2(FREE_LIST_DEPTH) bits;
- count;
- overflow_error.

Reset:
- entry[i] = NUM_ARCH_REGS + i; this matches the map table's identity reset, arch i -> phys i.
- head_ptr = 0, tail_ptr = 0, count = FREE_LIST_DEPTH (full).
- overflow_error = 0.
- Reset outputs: dequeue_ready = 1, dequeue_phys_reg_tag = NUM_ARCH_REGS, free_count = FREE_LIST_DEPTH.

Pointer wrap:
- Each pointer increments modulo FREE_LIST_DEPTH by explicit compare to DEPTH-1.
- A non-power-of-2 depth is legal.

Dequeue:
- dequeue_ready = (count != 0).
- On fire, head_ptr advances by 1.

Enqueue order in a cycle (up to 2 writes):
- The commit write goes to tail_ptr.
- The kill write goes to tail_ptr + (commit_free_valid ? 1 : 0), mod depth.
- tail_ptr advances by the number written.

Count and overflow:
- next_count = count + commit_free_valid + kill_free_valid - dequeue_fire.
- Dequeue is evaluated before enqueue, so a full list with simultaneous dequeue + one enqueue is legal.
- If next_count would exceed FREE_LIST_DEPTH: drop the kill write first, then the commit write, until it fits; set overflow_error; $display an error.
- Dropping is only reachable in a broken design.

No tag-uniqueness check (double-free) in this block.

## Timing
- dequeue_phys_reg_tag and dequeue_ready are valid combinationally from registers in the same cycle.
- The next tag appears the cycle after a fire.
- An enqueued tag is dequeueable no earlier than the next cycle, unless bypass is enabled (see Configuration).
- Dequeue on empty: no effect; rename must stall while dequeue_ready = 0.
- Reset asserted mid-operation discards all in-flight state immediately; no handshake completes that cycle.

## Configuration
- PHYS_REG_FREE_LIST_BYPASS_EN defined:
  - When count == 0 and commit_free_valid, dequeue_ready = 1 and dequeue_phys_reg_tag = commit_free_phys_reg_tag.
  - On fire, that tag is consumed without being written: no pointer movement for the pair, and count stays 0.
  - A kill write in the same cycle is enqueued normally.
- Undefined: empty means dequeue_ready = 0 regardless of same-cycle frees.

## Structure
- Shared package instr_types_pkg (already exists) holds phys_reg_tag_t, NUM_ARCH_REGS and NUM_PHYS_REGS.
- Add FREE_LIST_DEPTH and free_list_ptr_t there.
- No sub-module: pointer-increment logic is inline and the array is a flat register vector.

## Test plan
- Reset then dequeue 32 consecutive cycles -> tags 32..63 in order; dequeue_ready drops to 0 and free_count = 0 after cycle 32.
- From empty, commit-free 5 then kill-free 9 on consecutive cycles, then dequeue twice -> 5 then 9; free_count goes 0, 1, 2, 1, 0.
- From empty, commit tag 7 and kill tag 12 in the same cycle -> free_count = 2; dequeues return 7 then 12.
- Full list, dequeue + commit tag 3 in the same cycle -> head returns 32, free_count stays 32, and 3 appears after 63; overflow_error stays 0.
- Full list, commit tag 3 with no dequeue -> write dropped, overflow_error = 1 and sticky, free_count = 32; nRST low mid-test -> all state back to reset values.
- With BYPASS_EN at empty, commit tag 20 + dequeue_req -> dequeue_phys_reg_tag = 20 same cycle, free_count stays 0; without the macro, dequeue_ready = 0 that cycle.
